fsk_tx_ctrl: RTL and testbench
==============================

# fsk_tx_ctrl

Byte-serial FSK modulation controller that sits between a byte source and the two-carrier wave generator. It accepts bytes over a valid/ready handshake and shifts them out MSB-first, one bit every `BIT_CYCLES` clocks. For each bit it routes the mark carrier (`dout1`) or the space carrier (`dout2`) to a single registered FSK sample output. When no byte is being sent, it holds a fixed idle level.

## Interface

**Parameters**

- `DW`, 11: sample width; matches `dout1`/`dout2`.
- `BIT_CYCLES`, 50: clocks per transmitted bit; must be ≥ 2.
- `IDLE_LEVEL`, 11'h400: value driven on `fsk_out` when not transmitting.

**Ports**

- `clk`, input, 1: system clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `din`, input, 8: byte to transmit.
- `din_valid`, input, 1: `din` is valid.
- `din_ready`, output, 1: the controller accepts `din` this cycle.
- `mark_in`, input, DW: carrier used for bit = 1 (wave generator `dout1`).
- `space_in`, input, DW: carrier used for bit = 0 (wave generator `dout2`).
- `fsk_out`, output, DW: registered modulated sample.
- `fsk_valid`, output, 1: `fsk_out` carries modulated data (not idle level).
- `cur_bit`, output, 1: bit currently being transmitted; 0 in IDLE.
- `busy`, output, 1: state is SEND.
- `frame_done`, output, 1: one-cycle pulse at the end of each byte.

## Operation

**FSM states**

- IDLE
  - `din_ready` = 1.
  - On `din_valid` & `din_ready`: load the shift register with `din`, set `bit_cnt` = 7 and `cyc_cnt` = 0, go to SEND.
- SEND
  - `cur_bit` = `shreg[7]`.
  - `cyc_cnt` increments every cycle.
  - When `cyc_cnt` = `BIT_CYCLES`-1: `cyc_cnt` wraps to 0, `shreg` shifts left by 1, `bit_cnt` decrements.
  - The last cycle is `bit_cnt` = 0 and `cyc_cnt` = `BIT_CYCLES`-1. In that cycle:
    - `din_ready` = 1.
    - `frame_done` = 1.
    - If `din_valid` = 1: reload the next byte and stay in SEND (back-to-back, no gap).
    - Otherwise: go to IDLE.
- `din_ready` is 0 in every other SEND cycle. `din` is ignored whenever `din_ready` = 0.

**Output path (registered)**

- In SEND: `fsk_out` <= `cur_bit` ? `mark_in` : `space_in`, and `fsk_valid` <= 1.
- In IDLE: `fsk_out` <= `IDLE_LEVEL`, and `fsk_valid` <= 0.

**Reset values**

- State = IDLE.
- `shreg`, `bit_cnt`, `cyc_cnt` = 0.
- `fsk_out` = `IDLE_LEVEL`.
- `fsk_valid`, `cur_bit`, `busy`, `frame_done` = 0.
- `din_ready` = 1 combinationally once `rst` deasserts.

**Boundaries**

- Reset asserted mid-byte: the in-flight byte is discarded and all registers return to their reset values immediately.
- `din_valid` held high continuously: bytes stream with zero idle cycles between them.
- `cyc_cnt` width is `$clog2(BIT_CYCLES)`; no overflow beyond `BIT_CYCLES`-1.
- Carriers are not phase-aligned at bit boundaries. The switch happens on the exact cycle boundary.

## Timing

- Acceptance edge T0: `busy` = 1 and `cur_bit` = `din[7]` from T0+1.
- `fsk_out` / `fsk_valid` lag `cur_bit` by one cycle. The first modulated sample is visible at T0+2.
- Each bit occupies exactly `BIT_CYCLES` cycles on `cur_bit`, and the same on `fsk_out` shifted by 1.
- A byte takes 8×`BIT_CYCLES` cycles.
- `frame_done` is high in the cycle of T0+8×`BIT_CYCLES`.
- `fsk_valid` falls one cycle after SEND → IDLE.
- `mark_in` / `space_in` are sampled every cycle; no handshake with the wave generator.

## Structure

- Shared package `fsk_pkg` contains:
  - the state enum (IDLE, SEND);
  - `DW`;
  - the default `IDLE_LEVEL`;
  - the default `BIT_CYCLES`.
- One sub-module: `fsk_bit_timer`. It holds the `cyc_cnt` counter with `clr`/`en` inputs and produces the `bit_tick` output at `BIT_CYCLES`-1.
- FSM, shift register and output mux stay in `fsk_tx_ctrl`.

## Test plan

Bench settings: `BIT_CYCLES` = 4, `mark_in` = 11'h123, `space_in` = 11'h456 held constant.

- Single byte: send `din` = 8'hA5 once.
  - `cur_bit` sequence is 1,0,1,0,0,1,0,1, each 4 cycles.
  - `fsk_out` shows 4×123, 4×456, … over 32 cycles.
  - `frame_done` pulses once at T0+32.
  - `fsk_out` then returns to 11'h400 with `fsk_valid` = 0.
- Back-to-back: `din_valid` held high with 8'hFF then 8'h00.
  - `fsk_out` is 32 cycles of 123 then 32 cycles of 456, with no 11'h400 gap.
  - `din_ready` pulses exactly at T0+32.
- Handshake: assert `din_valid` mid-byte with a different `din`.
  - `din_ready` stays 0 and the byte is not taken until the last cycle.
  - The in-flight byte is unaltered.
- Reset mid-frame: assert `rst` at cycle 10 of a byte.
  - `fsk_out` = 11'h400 and `busy` = 0 immediately, without waiting for a clock.
  - No `frame_done` pulse.
  - A new byte sent after release transmits correctly.
- Idle: no `din_valid` for 100 cycles after reset.
  - `fsk_out` = 11'h400, `fsk_valid` = 0, `din_ready` = 1 throughout.

Source files
------------

// File: rtl/fsk_pkg.sv
// -----------------------------------------------------------------------------
// fsk_pkg
// Shared definitions for the FSK transmit controller slice.
//   FSK_DW          : width of carrier samples and of the modulated output
//   FSK_BIT_CYCLES  : default number of clocks each transmitted bit lasts
//   FSK_IDLE_LEVEL  : default sample value driven while nothing is being sent
//   fsk_state_t     : controller state (IDLE waiting for a byte, SEND shifting)
// -----------------------------------------------------------------------------
package fsk_pkg;

    localparam int FSK_DW = 11;
    localparam int FSK_BIT_CYCLES = 50;
    localparam logic [FSK_DW-1:0] FSK_IDLE_LEVEL = 11'h400;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsk_state_t;

endpackage

// File: rtl/fsk_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// fsk_tx_ctrl_if
// Bundles the byte handshake, the two carrier inputs and the modulated sample
// outputs of the FSK transmit controller.
//   din/din_valid/din_ready : byte source handshake (valid/ready)
//   mark_in/space_in        : carriers for bit 1 / bit 0 from the wave generator
//   fsk_out/fsk_valid       : registered modulated sample and its qualifier
//   cur_bit/busy/frame_done : transmit status
// Modports:
//   master : the byte source / system side that drives din and the carriers
//   slave  : the controller itself
// -----------------------------------------------------------------------------
interface fsk_tx_ctrl_if
    import fsk_pkg::*;
#(
    parameter int DW = FSK_DW
) ();

    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] mark_in;
    logic [DW-1:0] space_in;
    logic [DW-1:0] fsk_out;
    logic          fsk_valid;
    logic          cur_bit;
    logic          busy;
    logic          frame_done;

    modport master (
        output din,
        output din_valid,
        output mark_in,
        output space_in,
        input  din_ready,
        input  fsk_out,
        input  fsk_valid,
        input  cur_bit,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  din,
        input  din_valid,
        input  mark_in,
        input  space_in,
        output din_ready,
        output fsk_out,
        output fsk_valid,
        output cur_bit,
        output busy,
        output frame_done
    );

endinterface

// File: rtl/fsk_bit_timer.sv
// -----------------------------------------------------------------------------
// fsk_bit_timer
// Counts the clocks of the bit currently on the air and flags the final clock
// of each bit period.
//   clk, rst : clock and asynchronous active-high reset
//   clr      : force the count back to 0 (held while the controller is idle)
//   en       : advance the count this cycle
//   bit_tick : high on the last clock of a bit (count = BIT_CYCLES-1, en high)
// -----------------------------------------------------------------------------
module fsk_bit_timer
    import fsk_pkg::*;
#(
    parameter int BIT_CYCLES = FSK_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_tick
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cyc_cnt;

    // Cycle counter: wraps straight from BIT_CYCLES-1 back to 0 so it never
    // leaves the legal range, even when the width has spare codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt <= '0;
        end else if (clr) begin
            cyc_cnt <= '0;
        end else if (en) begin
            if (cyc_cnt == LAST_CNT) begin
                cyc_cnt <= '0;
            end else begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
        end
    end

    assign bit_tick = en && (cyc_cnt == LAST_CNT);

endmodule

// File: rtl/fsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// fsk_tx_ctrl
// Byte-serial FSK modulation controller. Accepts bytes over a valid/ready
// handshake, shifts them out MSB first with each bit lasting BIT_CYCLES
// clocks, and routes the mark carrier (bit 1) or space carrier (bit 0) to a
// registered sample output. Holds IDLE_LEVEL on the output when not sending.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : fsk_tx_ctrl_if slave port
//              din/din_valid/din_ready  byte handshake
//              mark_in/space_in         carrier samples, taken every cycle
//              fsk_out/fsk_valid        modulated sample, one cycle behind cur_bit
//              cur_bit                  bit on the air (0 when idle)
//              busy                     controller is in SEND
//              frame_done               pulse on the last clock of every byte
// -----------------------------------------------------------------------------
module fsk_tx_ctrl
    import fsk_pkg::*;
#(
    parameter int            DW         = FSK_DW,
    parameter int            BIT_CYCLES = FSK_BIT_CYCLES,
    parameter logic [DW-1:0] IDLE_LEVEL = FSK_IDLE_LEVEL
) (
    input  logic          clk,
    input  logic          rst,
    fsk_tx_ctrl_if.slave  bus
);

    fsk_state_t state;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       cur_bit_r;
    logic       busy_r;
    logic       bit_tick;
    logic       last_cycle;
    logic       take;

    fsk_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (state == IDLE),
        .en       (state == SEND),
        .bit_tick (bit_tick)
    );

    // The final clock of the last bit is the only SEND cycle that may take a
    // new byte; taking it there lets bytes stream with no idle gap.
    assign last_cycle = (state == SEND) && bit_tick && (bit_cnt == 3'd0);

    // Ready is held low while reset is asserted so nothing is offered as
    // accepted before the controller is running.
    assign bus.din_ready  = !rst && ((state == IDLE) || last_cycle);
    assign take           = bus.din_valid && bus.din_ready;
    assign bus.frame_done = last_cycle;
    assign bus.cur_bit    = cur_bit_r;
    assign bus.busy       = busy_r;

    // Control FSM with the shift register. busy and cur_bit are registered
    // alongside the state so they follow it exactly with no decode glitches;
    // cur_bit is loaded with the bit that will be on shreg[7] next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            cur_bit_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        state     <= SEND;
                        shreg     <= bus.din;
                        bit_cnt   <= 3'd7;
                        cur_bit_r <= bus.din[7];
                        busy_r    <= 1'b1;
                    end
                end
                SEND: begin
                    if (last_cycle) begin
                        if (take) begin
                            shreg     <= bus.din;
                            bit_cnt   <= 3'd7;
                            cur_bit_r <= bus.din[7];
                        end else begin
                            state     <= IDLE;
                            cur_bit_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end
                    end else if (bit_tick) begin
                        shreg     <= {shreg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt - 3'd1;
                        cur_bit_r <= shreg[6];
                    end
                end
            endcase
        end
    end

    // Output sample register. It selects on the registered cur_bit, so the
    // modulated stream trails cur_bit by one clock; the switch between
    // carriers happens on that clock edge with no phase alignment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fsk_out   <= IDLE_LEVEL;
            bus.fsk_valid <= 1'b0;
        end else if (state == SEND) begin
            bus.fsk_out   <= cur_bit_r ? bus.mark_in : bus.space_in;
            bus.fsk_valid <= 1'b1;
        end else begin
            bus.fsk_out   <= IDLE_LEVEL;
            bus.fsk_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fsk_tx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fsk_tx_ctrl
// Self-checking bench for fsk_tx_ctrl. Every accepted byte is expanded into the
// per-cycle streams it must produce (cur_bit, frame_done/din_ready marker and
// modulated sample); a monitor pops and compares those streams whenever the
// DUT reports busy or fsk_valid.
// -----------------------------------------------------------------------------
module tb_fsk_tx_ctrl;

    localparam int          BC     = 4;
    localparam logic [10:0] MARK   = 11'h123;
    localparam logic [10:0] SPACE  = 11'h456;
    localparam logic [10:0] IDLE_V = 11'h400;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fsk_tx_ctrl_if #(.DW(11)) bus ();

    fsk_tx_ctrl #(
        .DW         (11),
        .BIT_CYCLES (BC),
        .IDLE_LEVEL (IDLE_V)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [10:0] expOut[$];
    logic        expBit[$];
    logic        expLast[$];
    int          curRun  = 0;
    int          lastRun = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a byte goes out MSB first, each bit held for BC cycles,
    // a 1 selecting the mark carrier; the final cycle of the byte is marked.
    function automatic void pushByte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            for (int c = 0; c < BC; c++) begin
                expBit.push_back(b[i]);
                expLast.push_back((i == 0) && (c == BC - 1));
                expOut.push_back(b[i] ? MARK : SPACE);
            end
        end
    endfunction

    // Offer a byte and wait for it to be taken; called 1 ns after a rising edge.
    task automatic applyStimulus(input logic [7:0] b, input bit keepValid);
        bit ok;
        ok = 1'b0;
        bus.din       = b;
        bus.din_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.din_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.din_valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            pushByte(b);
            if (!keepValid) bus.din_valid = 1'b0;
        end
    endtask

    // Wait, with a cycle budget, until every expected sample has been seen.
    task automatic waitDrain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            #1;
            if (expOut.size() == 0 && expBit.size() == 0 &&
                bus.busy === 1'b0 && bus.fsk_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput(name, 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT status and samples against the expected streams.
    always @(negedge clk) begin
        logic b;
        logic l;
        if (!rst) begin
            if (bus.busy === 1'b1) begin
                if (expBit.size() == 0) begin
                    checkOutput("busy_unexpected", 32'd1, 32'd0);
                end else begin
                    b = expBit.pop_front();
                    l = expLast.pop_front();
                    checkOutput("cur_bit", bus.cur_bit, b);
                    checkOutput("frame_done", bus.frame_done, l);
                    checkOutput("din_ready_send", bus.din_ready, l);
                end
            end else begin
                checkOutput("cur_bit_idle", bus.cur_bit, 0);
                checkOutput("frame_done_idle", bus.frame_done, 0);
                checkOutput("din_ready_idle", bus.din_ready, 1);
            end
            if (bus.fsk_valid === 1'b1) begin
                if (expOut.size() == 0) checkOutput("fsk_valid_unexpected", 32'd1, 32'd0);
                else checkOutput("fsk_out", bus.fsk_out, expOut.pop_front());
                curRun++;
            end else begin
                checkOutput("fsk_out_idle", bus.fsk_out, IDLE_V);
                if (curRun != 0) lastRun = curRun;
                curRun = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        bit         keep;
        int         gap;

        bus.din       = 8'h00;
        bus.din_valid = 1'b0;
        bus.mark_in   = MARK;
        bus.space_in  = SPACE;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_fsk_out", bus.fsk_out, IDLE_V);
        checkOutput("reset_fsk_valid", bus.fsk_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_cur_bit", bus.cur_bit, 0);
        checkOutput("reset_frame_done", bus.frame_done, 0);
        rst = 1'b0;
        #1;
        checkOutput("din_ready_after_reset", bus.din_ready, 1);

        $display("[TB] idle for 100 cycles");
        repeat (100) @(posedge clk);
        #1;

        $display("[TB] single byte A5");
        applyStimulus(8'hA5, 1'b0);
        waitDrain("drain_single");

        $display("[TB] back-to-back FF then 00");
        lastRun = 0;
        applyStimulus(8'hFF, 1'b1);
        applyStimulus(8'h00, 1'b0);
        waitDrain("drain_b2b");
        checkOutput("b2b_run_length", lastRun, 64);

        $display("[TB] handshake while busy");
        applyStimulus(8'h3C, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        applyStimulus(8'hC3, 1'b0);
        waitDrain("drain_handshake");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h96, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        checkOutput("pre_rst_busy", bus.busy, 1);
        #1;
        rst = 1'b1;
        expOut.delete();
        expBit.delete();
        expLast.delete();
        curRun = 0;
        #1;
        checkOutput("rst_mid_fsk_out", bus.fsk_out, IDLE_V);
        checkOutput("rst_mid_busy", bus.busy, 0);
        checkOutput("rst_mid_fsk_valid", bus.fsk_valid, 0);
        checkOutput("rst_mid_frame_done", bus.frame_done, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(8'h5A, 1'b0);
        waitDrain("drain_after_reset");

        $display("[TB] random bytes");
        for (int i = 0; i < 20; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            rb   = 8'($urandom);
            keep = (i != 19) && ($urandom_range(0, 1) == 1);
            applyStimulus(rb, keep);
        end
        waitDrain("drain_random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
